// File: rtl/vertex_viewport_mapper.sv
// Perspective divide and viewport mapping for one clip-space vertex at a time.
// Define VERTEX_VIEWPORT_CLAMP_EN to saturate screen/depth outputs instead of wrapping.
module vertex_viewport_mapper #(
    parameter int IN_W     = 32,
    parameter int FRAC     = 16,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int X_W      = 11,
    parameter int Y_W      = 11,
    parameter int DEPTH_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in_x,
    input  logic signed [IN_W-1:0] in_y,
    input  logic signed [IN_W-1:0] in_z,
    input  logic signed [IN_W-1:0] in_w,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [X_W-1:0]         out_sx,
    output logic [Y_W-1:0]         out_sy,
    output logic [DEPTH_W-1:0]     out_depth,
    output logic                   out_clipped
);
    localparam int QW  = FRAC + 3;
    localparam int SW  = FRAC + 4;
    localparam int MW  = FRAC + 48;
    localparam int SPW = $clog2(FRAC + 3);

    localparam logic signed [SW-1:0] ONE_Q  = SW'(1) << FRAC;
    localparam logic signed [MW-1:0] ONE_E  = MW'(1) << FRAC;
    localparam logic signed [MW-1:0] SCR_WE = MW'(SCREEN_W);
    localparam logic signed [MW-1:0] SCR_HE = MW'(SCREEN_H);
    localparam logic signed [MW-1:0] DMAX_E = (MW'(1) << DEPTH_W) - MW'(1);

    typedef enum logic [1:0] {IDLE, DIV, MAP, OUT} state_t;

    state_t                 state;
    logic signed [IN_W-1:0] cx, cy, cz, cw;
    logic [1:0]             comp;
    logic [SPW-1:0]         step;
    logic [IN_W-1:0]        rem;
    logic [QW-1:0]          dsr;
    logic [QW-1:0]          quo;
    logic signed [SW-1:0]   q_x, q_y, q_z;
    logic                   behind;

    logic signed [IN_W-1:0] cur_c;
    logic                   cur_neg;
    logic [IN_W-1:0]        cur_mag, w_mag, rem_src, rem_nx;
    logic [QW-1:0]          bits_src, quo_src, dsr_nx, quo_nx, qmag;
    logic [IN_W:0]          trial;
    logic                   ge, sat;
    logic signed [SW-1:0]   q_pos, q_final;

    // One restoring step; step 0 seeds the remainder with |c|>>3 since the quotient fits in FRAC+3 bits.
    always_comb begin
        cur_c    = (comp == 2'd0) ? cx : ((comp == 2'd1) ? cy : cz);
        cur_neg  = cur_c[IN_W-1];
        cur_mag  = cur_neg ? IN_W'(-cur_c) : IN_W'(cur_c);
        w_mag    = cw;
        sat      = {3'b000, cur_mag} >= {w_mag, 3'b000};
        rem_src  = (step == '0) ? (cur_mag >> 3) : rem;
        bits_src = (step == '0) ? {cur_mag[2:0], {FRAC{1'b0}}} : dsr;
        quo_src  = (step == '0) ? '0 : quo;
        trial    = {rem_src, bits_src[QW-1]};
        ge       = trial >= {1'b0, w_mag};
        rem_nx   = ge ? (trial[IN_W-1:0] - w_mag) : trial[IN_W-1:0];
        dsr_nx   = {bits_src[QW-2:0], 1'b0};
        quo_nx   = {quo_src[QW-2:0], ge};
        qmag     = sat ? '1 : quo_nx;
        q_pos    = signed'({1'b0, qmag});
        q_final  = cur_neg ? -q_pos : q_pos;
    end

    logic signed [MW-1:0] sx_full, sy_full, d_full;
    logic [X_W-1:0]       sx_v;
    logic [Y_W-1:0]       sy_v;
    logic [DEPTH_W-1:0]   d_v;
    logic                 clip_v;

    always_comb begin
        sx_full = ((MW'(q_x) + ONE_E) * SCR_WE) >>> (FRAC + 1);
        sy_full = ((ONE_E - MW'(q_y)) * SCR_HE) >>> (FRAC + 1);
        d_full  = ((MW'(q_z) + ONE_E) * DMAX_E) >>> (FRAC + 1);
        clip_v  = (q_x > ONE_Q) || (q_x < -ONE_Q) || (q_y > ONE_Q) || (q_y < -ONE_Q)
               || (q_z > ONE_Q) || (q_z < -ONE_Q);
`ifdef VERTEX_VIEWPORT_CLAMP_EN
        sx_v = (sx_full < 0) ? '0 : ((sx_full > MW'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1) : sx_full[X_W-1:0]);
        sy_v = (sy_full < 0) ? '0 : ((sy_full > MW'(SCREEN_H - 1)) ? Y_W'(SCREEN_H - 1) : sy_full[Y_W-1:0]);
        d_v  = (d_full < 0) ? '0 : ((d_full > DMAX_E) ? '1 : d_full[DEPTH_W-1:0]);
`else
        sx_v = sx_full[X_W-1:0];
        sy_v = sy_full[Y_W-1:0];
        d_v  = d_full[DEPTH_W-1:0];
`endif
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cx          <= '0;
            cy          <= '0;
            cz          <= '0;
            cw          <= '0;
            comp        <= '0;
            step        <= '0;
            rem         <= '0;
            dsr         <= '0;
            quo         <= '0;
            q_x         <= '0;
            q_y         <= '0;
            q_z         <= '0;
            behind      <= 1'b0;
            out_sx      <= '0;
            out_sy      <= '0;
            out_depth   <= '0;
            out_clipped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cx   <= in_x;
                        cy   <= in_y;
                        cz   <= in_z;
                        cw   <= in_w;
                        comp <= '0;
                        step <= '0;
                        if (in_w <= 0) begin
                            behind <= 1'b1;
                            q_x    <= '0;
                            q_y    <= '0;
                            q_z    <= '0;
                            state  <= MAP;
                        end else begin
                            behind <= 1'b0;
                            state  <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_nx;
                    dsr <= dsr_nx;
                    quo <= quo_nx;
                    if (step == SPW'(FRAC + 2)) begin
                        step <= '0;
                        case (comp)
                            2'd0:    q_x <= q_final;
                            2'd1:    q_y <= q_final;
                            default: q_z <= q_final;
                        endcase
                        if (comp == 2'd2) begin
                            state <= MAP;
                        end else begin
                            comp <= comp + 2'd1;
                        end
                    end else begin
                        step <= step + SPW'(1);
                    end
                end
                MAP: begin
                    out_sx      <= behind ? '0 : sx_v;
                    out_sy      <= behind ? '0 : sy_v;
                    out_depth   <= behind ? '0 : d_v;
                    out_clipped <= behind | clip_v;
                    state       <= OUT;
                end
                default: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/vertex_viewport_mapper.md
# vertex_viewport_mapper

Per-vertex perspective-divide and viewport stage directly downstream of the vertex processor. It takes a transformed clip-space vertex (x, y, z, w as signed integers) and divides x, y and z by w with one shared iterative restoring divider. It then maps the normalized result to integer screen coordinates and a depth value, and flags vertices that lie behind the eye or outside the view volume. Both ports use valid/ready handshakes; the block holds one vertex at a time.

## Interface
- IN_W, 32: width of the signed clip-space input components.
- FRAC, 16: fractional bits of the internal normalized-device-coordinate (NDC) quotient.
- SCREEN_W, 640: viewport width in pixels.
- SCREEN_H, 480: viewport height in pixels.
- X_W, 11: width of the screen-x output.
- Y_W, 11: width of the screen-y output.
- DEPTH_W, 16: width of the depth output.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  input vertex valid.
- in_ready  out  1  block can accept a vertex.
- in_x, in_y, in_z, in_w  in  IN_W each  signed clip-space components.
- out_valid  out  1  mapped vertex valid.
- out_ready  in  1  downstream accepts the mapped vertex.
- out_sx  out  X_W  screen x.
- out_sy  out  Y_W  screen y, with row 0 at the top.
- out_depth  out  DEPTH_W  unsigned depth.
- out_clipped  out  1  vertex is behind the eye or outside NDC [-1, 1].

## Operation
- FSM states: IDLE, DIV, MAP, OUT.
- IDLE
  - in_ready=1.
  - On in_valid, capture x, y, z, w.
  - If w<=0, go to MAP with all quotients forced to 0 and a behind flag set.
  - Otherwise go to DIV.
- DIV
  - Three serial divisions: x, then y, then z.
  - Each division is restoring and unsigned on magnitudes, computing (|c|<<FRAC)/|w|.
  - Each produces FRAC+3 quotient bits, one bit per cycle, truncating toward zero.
  - The sign is applied after the division.
  - Pre-check: if |c| >= 8·|w|, the quotient saturates to ±(2^(FRAC+3)-1) and the divider still spends its full cycles.
  - A step counter runs 0..FRAC+2; a component index runs 0..2.
- MAP (1 cycle), with one = 2^FRAC:
  - sx = ((q_x+one)·SCREEN_W) >>> (FRAC+1).
  - sy = ((one−q_y)·SCREEN_H) >>> (FRAC+1).
  - depth = ((q_z+one)·(2^DEPTH_W−1)) >>> (FRAC+1).
  - All intermediates are signed and wide enough that nothing overflows.
  - clipped = behind OR |q_x|>one OR |q_y|>one OR |q_z|>one (strictly greater than).
  - Behind vertices output sx=sy=depth=0.
  - Results are registered; go to OUT.
- OUT
  - out_valid=1; outputs are held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE.
- No overlap between vertices: in_ready=0 in DIV, MAP and OUT.
- Reset at any time, including mid-division, returns the FSM to IDLE and clears all state.
- Reset values: out_valid=0, in_ready=1, out_sx=0, out_sy=0, out_depth=0, out_clipped=0.

## Timing
- The input handshake on edge 0 enters DIV.
- out_valid rises 3·(FRAC+3)+2 cycles after the input handshake: 59 with the default FRAC=16.
- A behind vertex (w<=0) has out_valid 2 cycles after its input handshake.
- in_ready rises the cycle after the output handshake, so peak throughput is one vertex per 3·(FRAC+3)+3 cycles.
- Backpressure: out_ready low for any number of cycles holds all outputs unchanged.

## Configuration
- VERTEX_VIEWPORT_CLAMP_EN defined:
  - sx is saturated to [0, SCREEN_W−1].
  - sy is saturated to [0, SCREEN_H−1].
  - depth is saturated to [0, 2^DEPTH_W−1].
- Not defined:
  - Each output is the low X_W, Y_W or DEPTH_W bits of the unclamped two's-complement result, so values wrap.
- out_clipped is identical in both builds.

## Test plan
- Centre vertex: x=0, y=0, z=0, w=256 → sx=320, sy=240, depth=32767, clipped=0; out_valid exactly 59 cycles after the input handshake.
- Edge vertex: x=256, y=−256, z=256, w=256
  - With the macro: sx=639, sy=479, depth=65535, clipped=0.
  - Without the macro: sx=640, sy=480, depth=65535.
- Outside vertex: x=512, w=256, y=z=0 → clipped=1.
  - With the macro: sx=639.
  - Without the macro: sx=960.
- Overflow vertex: x=2048, w=256 → quotient saturated, clipped=1.
- Behind eye: w=0 with any x, y, z, and separately w=−5 → sx=sy=depth=0, clipped=1, out_valid 2 cycles after the handshake.
- Handshake and reset:
  - Hold out_ready=0 for 10 cycles → outputs stable and in_ready=0 throughout; it rises 1 cycle after acceptance.
  - Assert rst_n=0 mid-DIV → immediately out_valid=0, in_ready=1, all outputs 0; the next vertex processes correctly.
